// File: rtl/tom_move_ctrl.sv
// tom_move_ctrl
// Per-frame movement controller for the Tom sprite. It turns keyboard key
// levels into registered sprite coordinates: horizontal walking plus a
// jump/rise/fall state machine with gravity. All position, velocity and state
// updates happen in the frame_tick cycle, and the outputs hold between ticks.
//
// Ports:
//   clk         - system clock
//   rst         - synchronous reset, active-high
//   frame_tick  - one-cycle pulse per frame (start of vblank)
//   key_left    - left key held (level)
//   key_right   - right key held (level)
//   key_jump    - jump key held (level); only a rising edge starts a jump
//   tom_x       - sprite left x
//   tom_y       - sprite top y (y grows downward)
//   on_ground   - 1 while the vertical state is GROUND
//   facing_left - last horizontal direction moved
//
// Build option: define SCREEN_WRAP_EN to make horizontal movement wrap around
// the screen edges instead of clamping at them.

module tom_move_ctrl #(
  parameter int X_SPAWN  = 50,
  parameter int Y_SPAWN  = 50,
  parameter int GROUND_Y = 400,
  parameter int X_MAX    = 640,
  parameter int TOM_W    = 32,
  parameter int STEP_X   = 2,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1,
  parameter int V_MAX    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  output logic [9:0] tom_x,
  output logic [9:0] tom_y,
  output logic       on_ground,
  output logic       facing_left
);

  localparam logic [1:0] ST_GROUND = 2'd0;
  localparam logic [1:0] ST_RISE   = 2'd1;
  localparam logic [1:0] ST_FALL   = 2'd2;

  // Arithmetic is carried out in 11 bits so sums never wrap around 10 bits.
  localparam logic [10:0] L_STEP   = 11'(STEP_X);
  localparam logic [10:0] L_XLIM   = 11'(X_MAX - TOM_W);
  localparam logic [10:0] L_GROUND = 11'(GROUND_Y);
  localparam logic [10:0] L_JUMPY  = 11'(GROUND_Y - JUMP_V);
  localparam logic [4:0]  L_GRAV   = 5'(GRAVITY);
  localparam logic [4:0]  L_VMAX   = 5'(V_MAX);
  localparam logic [4:0]  L_VJUMP  = 5'(JUMP_V - GRAVITY);

  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [4:0]  r_vel;
  logic [1:0]  r_state;
  logic        r_on_ground;
  logic        r_facing_left;
  logic        r_jump_pend;
  logic        r_key_jump_d;

  logic        w_jump_edge;
  logic        w_jump_now;
  logic        w_mv_left;
  logic        w_mv_right;
  logic [10:0] w_x11;
  logic [10:0] w_y11;
  logic [10:0] w_rise_y;
  logic [5:0]  w_fall_sum;
  logic [4:0]  w_fall_v;
  logic [10:0] w_fall_y;
  logic [9:0]  w_x_n;
  logic [9:0]  w_y_n;
  logic [4:0]  w_vel_n;
  logic [1:0]  w_state_n;
  logic        w_face_n;

  // An edge arriving in the same cycle as the tick still counts for that tick.
  assign w_jump_edge = key_jump & ~r_key_jump_d;
  assign w_jump_now  = r_jump_pend | w_jump_edge;

  assign w_mv_left  = key_left & ~key_right;
  assign w_mv_right = key_right & ~key_left;

  assign w_x11 = {1'b0, r_x};
  assign w_y11 = {1'b0, r_y};

  // Candidate results for the RISE and FALL steps.
  assign w_rise_y   = (w_y11 > {6'b0, r_vel}) ? (w_y11 - {6'b0, r_vel}) : 11'd0;
  assign w_fall_sum = {1'b0, r_vel} + {1'b0, L_GRAV};
  assign w_fall_v   = (w_fall_sum > {1'b0, L_VMAX}) ? L_VMAX : w_fall_sum[4:0];
  assign w_fall_y   = w_y11 + {6'b0, w_fall_v};

  // Next-state logic; everything holds unless this is a frame_tick cycle.
  always_comb begin
    w_x_n     = r_x;
    w_y_n     = r_y;
    w_vel_n   = r_vel;
    w_state_n = r_state;
    w_face_n  = r_facing_left;
    if (frame_tick) begin
      if (w_mv_left) begin
        w_face_n = 1'b1;
        if (w_x11 < L_STEP) begin
`ifdef SCREEN_WRAP_EN
          w_x_n = L_XLIM[9:0];
`else
          w_x_n = 10'd0;
`endif
        end else begin
          w_x_n = r_x - L_STEP[9:0];
        end
      end else if (w_mv_right) begin
        w_face_n = 1'b0;
        if ((w_x11 + L_STEP) > L_XLIM) begin
`ifdef SCREEN_WRAP_EN
          w_x_n = 10'd0;
`else
          w_x_n = L_XLIM[9:0];
`endif
        end else begin
          w_x_n = r_x + L_STEP[9:0];
        end
      end

      case (r_state)
        ST_GROUND: begin
          if (w_jump_now) begin
            w_y_n     = L_JUMPY[9:0];
            w_vel_n   = L_VJUMP;
            w_state_n = ST_RISE;
          end
        end
        ST_RISE: begin
          w_y_n = w_rise_y[9:0];
          if ((r_vel <= L_GRAV) || (w_rise_y == 11'd0)) begin
            w_vel_n   = 5'd0;
            w_state_n = ST_FALL;
          end else begin
            w_vel_n = r_vel - L_GRAV;
          end
        end
        default: begin
          if (w_fall_y >= L_GROUND) begin
            w_y_n     = L_GROUND[9:0];
            w_vel_n   = 5'd0;
            w_state_n = ST_GROUND;
          end else begin
            w_y_n   = w_fall_y[9:0];
            w_vel_n = w_fall_v;
          end
        end
      endcase
    end
  end

  // State registers; a pending jump is cleared by every tick, used or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x           <= 10'(X_SPAWN);
      r_y           <= 10'(Y_SPAWN);
      r_vel         <= 5'd0;
      r_state       <= ST_FALL;
      r_on_ground   <= 1'b0;
      r_facing_left <= 1'b0;
      r_jump_pend   <= 1'b0;
      r_key_jump_d  <= 1'b0;
    end else begin
      r_key_jump_d  <= key_jump;
      r_x           <= w_x_n;
      r_y           <= w_y_n;
      r_vel         <= w_vel_n;
      r_state       <= w_state_n;
      r_on_ground   <= (w_state_n == ST_GROUND);
      r_facing_left <= w_face_n;
      if (frame_tick) begin
        r_jump_pend <= 1'b0;
      end else if (w_jump_edge) begin
        r_jump_pend <= 1'b1;
      end
    end
  end

  assign tom_x       = r_x;
  assign tom_y       = r_y;
  assign on_ground   = r_on_ground;
  assign facing_left = r_facing_left;

endmodule
